// File: rtl/riscv_pkg.sv
// Shared definitions for the core front end: fetch states, instruction
// field positions and architectural constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2,
        F_HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_BIT  = 30;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (redirect > branch > sequential) with alignment check.
module next_pc_sel (
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic [31:0] pc_cur,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc_cur + 32'd4;
        if (flush)
            next_pc = flush_pc;
        else if (pc_src)
            next_pc = pc_target;
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Front end: owns the PC, fetches over a req/rvalid handshake and holds one
// instruction plus its decoded fields until the core accepts it.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        misalign_err
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         drop;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_sel u_next_pc_sel (
        .flush      (flush),
        .flush_pc   (flush_pc),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .pc_cur     (pc_out),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign imem_addr = pc;
    assign op        = instr[OP_LSB +: 7];
    assign rd        = instr[RD_LSB +: 5];
    assign funct3    = instr[F3_LSB +: 3];
    assign rs1       = instr[RS1_LSB +: 5];
    assign rs2       = instr[RS2_LSB +: 5];
    assign funct7    = instr[F7_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= F_REQ;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            pc_out       <= RESET_PC;
            drop         <= 1'b0;
            misalign_err <= 1'b0;
        end else if (flush) begin
            pc           <= next_pc;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            misalign_err <= misaligned;
            if (misaligned) begin
                state    <= F_HALT;
                imem_req <= 1'b0;
                drop     <= 1'b0;
            end else if (state == F_WAIT && !imem_rvalid) begin
                // Response still in flight: swallow it when it lands.
                drop     <= 1'b1;
                imem_req <= 1'b0;
            end else begin
                state    <= F_REQ;
                imem_req <= 1'b1;
                drop     <= 1'b0;
            end
        end else begin
            unique case (state)
                F_REQ: begin
                    // Out of reset the request pulse is raised one cycle late.
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        state    <= F_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                F_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop     <= 1'b0;
                            state    <= F_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                            state       <= F_HOLD;
                        end
                    end
                end
                F_HOLD: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= F_HALT;
                        end else begin
                            pc       <= next_pc;
                            state    <= F_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                F_HALT: begin
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of fetch/accept vectors plus
// hand-written redirect, misalignment and reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  rs1, rs2, rd;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt = 0;
    logic [31:0] addr_q = 32'h0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .pc_out       (pc_out),
        .op           (op),
        .funct3       (funct3),
        .funct7       (funct7),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h0050_0093;
        return (a << 12) | 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction memory: one response lat cycles after each request.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt = 0;
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem_word(addr_q);
                end
            end
            if (imem_req) begin
                chk("one_outstanding", 32'(cnt != 0), 32'd0);
                addr_q = imem_addr;
                cnt = lat;
            end
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    typedef struct {
        int          hold;
        logic        src;
        logic [31:0] tgt;
        int          next_lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] s_instr, s_pc;
        int n;

        vecs[0] = '{0, 1'b0, 32'h0,         1, 32'h0,         32'h0050_0093, 32'h4};
        vecs[1] = '{5, 1'b0, 32'h0,         1, 32'h4,         32'h0000_4013, 32'h8};
        vecs[2] = '{2, 1'b1, 32'h40,        1, 32'h8,         32'h0000_8013, 32'h40};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFFC, 1, 32'h40,        32'h0004_0013, 32'hFFFF_FFFC};
        vecs[4] = '{0, 1'b0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_C013, 32'h0};
        vecs[5] = '{0, 1'b1, 32'h20,        4, 32'h0,         32'h0050_0093, 32'h20};

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        for (int i = 0; i < 6; i++) begin
            wait_valid("vec_valid");
            chk("vec_pc_out", pc_out, vecs[i].exp_pc);
            chk("vec_instr", instr, vecs[i].exp_instr);
            chk("vec_op", 32'(op), 32'(vecs[i].exp_instr[6:0]));
            chk("vec_rd", 32'(rd), 32'(vecs[i].exp_instr[11:7]));
            s_instr = instr;
            s_pc = pc_out;
            for (int h = 0; h < vecs[i].hold; h++) begin
                instr_ready = 1'b0;
                pc_src = 1'b1;
                pc_target = 32'h80;
                @(negedge clk);
                chk("hold_req", 32'(imem_req), 32'd0);
                chk("hold_instr", instr, s_instr);
                chk("hold_pc", pc_out, s_pc);
            end
            instr_ready = 1'b1;
            pc_src = vecs[i].src;
            pc_target = vecs[i].tgt;
            lat = vecs[i].next_lat;
            @(negedge clk);
            instr_ready = 1'b0;
            pc_src = 1'b0;
            chk("next_req", 32'(imem_req), 32'd1);
            chk("next_addr", imem_addr, vecs[i].exp_next);
            chk("acc_valid", 32'(instr_valid), 32'd0);
            chk("acc_instr", instr, NOP);
        end

        // Flush while waiting on a slow response to 0x20.
        @(negedge clk);
        flush = 1'b1;
        flush_pc = 32'h100;
        @(negedge clk);
        flush = 1'b0;
        lat = 1;
        n = 0;
        while (!imem_req && n < 20) begin
            if (instr_valid) chk("flush_no_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("flush_req", 32'(imem_req), 32'd1);
        chk("flush_addr", imem_addr, 32'h100);
        wait_valid("flush_valid");
        chk("flush_pc_out", pc_out, 32'h100);
        chk("flush_instr", instr, 32'h0010_0013);

        // Misaligned branch target halts fetch until a redirect.
        instr_ready = 1'b1;
        pc_src = 1'b1;
        pc_target = 32'h42;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_src = 1'b0;
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (imem_req) n++;
            @(negedge clk);
        end
        chk("halt_no_req", 32'(n), 32'd0);
        flush = 1'b1;
        flush_pc = 32'h200;
        @(negedge clk);
        flush = 1'b0;
        chk("resume_err", 32'(misalign_err), 32'd0);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h200);
        wait_valid("resume_valid");
        chk("resume_pc_out", pc_out, 32'h200);
        chk("resume_instr", instr, 32'h0020_0013);

        // Reset asserted mid-fetch.
        instr_ready = 1'b1;
        lat = 4;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h204);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, NOP);
        chk("mid_rst_pc_out", pc_out, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        wait_valid("post_rst_valid");
        chk("post_rst_instr", instr, 32'h0050_0093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
